// File: rtl/dac_cfg_pkg.sv
// Shared types, limits and helpers for the DAC serial configuration loader.
// The legacy ST_* constants mirror the receiver state enum one-to-one.
package dac_cfg_pkg;

    localparam int NCH_MAX = 16;
    localparam int W_MAX   = 16;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_ADDR   = 3'd1,
        RX_DATA   = 3'd2,
        RX_PAR    = 3'd3,
        RX_COMMIT = 3'd4
    } rx_state_e;

    localparam logic [2:0] ST_IDLE   = 3'(RX_IDLE);
    localparam logic [2:0] ST_ADDR   = 3'(RX_ADDR);
    localparam logic [2:0] ST_DATA   = 3'(RX_DATA);
    localparam logic [2:0] ST_PAR    = 3'(RX_PAR);
    localparam logic [2:0] ST_COMMIT = 3'(RX_COMMIT);

    function automatic int addr_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    localparam int AW_MAX    = addr_width(NCH_MAX);
    localparam int PAR_VEC_W = AW_MAX + W_MAX + 1;

    // Start bit + address + data + parity.
    function automatic int frame_len(input int aw, input int w);
        return aw + w + 2;
    endfunction

    function automatic logic odd_ones(input logic [PAR_VEC_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/cfg_frame_rx.sv
// Serial frame receiver: start detect, address/data shift, even-parity and
// address-range check. Results are held stable while commit is high.
module cfg_frame_rx
    import dac_cfg_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = 8,
    parameter int AW  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sdi,
    input  logic          sen,
    output logic [AW-1:0] addr,
    output logic [W-1:0]  data,
    output logic          commit,
    output logic          ok,
    output logic          busy
);

    localparam int            CW        = $clog2(W_MAX + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(AW - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(W - 1);
    localparam logic [AW:0]   NCH_LIM   = (AW + 1)'(NCH);

    logic [2:0]    state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic [AW-1:0] addr_r, addr_nxt_s;
    logic [W-1:0]  data_r, data_nxt_s;
    logic          ok_r, ok_nxt_s;
    logic          busy_r;
    logic          commit_r;

    // Next-state, shift and check logic; only qualified bits advance the frame.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        addr_nxt_s  = addr_r;
        data_nxt_s  = data_r;
        ok_nxt_s    = ok_r;
        case (state_r)
            ST_IDLE: begin
                if (sen && sdi) begin
                    state_nxt_s = ST_ADDR;
                    cnt_nxt_s   = '0;
                    addr_nxt_s  = '0;
                    data_nxt_s  = '0;
                    ok_nxt_s    = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (sen) begin
                    addr_nxt_s    = addr_r << 1;
                    addr_nxt_s[0] = sdi;
                    if (cnt_r == ADDR_LAST) begin
                        state_nxt_s = ST_DATA;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (sen) begin
                    data_nxt_s    = data_r << 1;
                    data_nxt_s[0] = sdi;
                    if (cnt_r == DATA_LAST) begin
                        state_nxt_s = ST_PAR;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PAR: begin
                if (sen) begin
                    // Even parity over address, data and the parity bit itself.
                    ok_nxt_s    = ~odd_ones(PAR_VEC_W'({addr_r, data_r, sdi}))
                                  && ({1'b0, addr_r} < NCH_LIM);
                    state_nxt_s = ST_COMMIT;
                end else begin
                    state_nxt_s = ST_PAR;
                end
            end
            ST_COMMIT: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Receiver state registers and registered status decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            addr_r   <= '0;
            data_r   <= '0;
            ok_r     <= 1'b0;
            busy_r   <= 1'b0;
            commit_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            addr_r   <= addr_nxt_s;
            data_r   <= data_nxt_s;
            ok_r     <= ok_nxt_s;
            busy_r   <= (state_nxt_s != ST_IDLE);
            commit_r <= (state_nxt_s == ST_COMMIT);
        end
    end

    assign addr   = addr_r;
    assign data   = data_r;
    assign commit = commit_r;
    assign ok     = ok_r;
    assign busy   = busy_r;

endmodule

// File: rtl/dac_cfg_loader.sv
// Addressed, parity-checked serial loader feeding NCH double-buffered
// W-bit channel registers (shadow bank -> active bank).
module dac_cfg_loader
    import dac_cfg_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sdi,
    input  logic           sen,
    input  logic           update,
    input  logic           auto_upd,
    output logic [NCH*W-1:0] cfg_o,
    output logic [NCH-1:0] loaded_o,
    output logic           busy_o,
    output logic           frame_ok_o,
    output logic           err_o
);

    localparam int AW = addr_width(NCH);

    logic [AW-1:0] addr_s;
    logic [W-1:0]  data_s;
    logic          commit_s;
    logic          ok_s;
    logic          busy_s;
    logic          acc_s;
    logic          rej_s;

    logic [W-1:0]   shadow_r [NCH];
    logic [W-1:0]   active_r [NCH];
    logic [NCH-1:0] loaded_r;
    logic           frame_ok_r;
    logic           err_r;

    cfg_frame_rx #(
        .NCH (NCH),
        .W   (W),
        .AW  (AW)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .sdi    (sdi),
        .sen    (sen),
        .addr   (addr_s),
        .data   (data_s),
        .commit (commit_s),
        .ok     (ok_s),
        .busy   (busy_s)
    );

    assign acc_s = commit_s & ok_s;
    assign rej_s = commit_s & ~ok_s;

    // Shadow bank and loaded flags take only accepted frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                shadow_r[k] <= '0;
            end
            loaded_r <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (acc_s && (addr_s == AW'(k))) begin
                    shadow_r[k] <= data_s;
                    loaded_r[k] <= 1'b1;
                end
            end
        end
    end

    // Active bank: a fresh commit beats the stale shadow when update coincides.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                active_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (acc_s && (addr_s == AW'(k)) && (auto_upd || update)) begin
                    active_r[k] <= data_s;
                end else if (update) begin
                    active_r[k] <= shadow_r[k];
                end
            end
        end
    end

    // One-cycle status pulses following the commit cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_ok_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            frame_ok_r <= acc_s;
            err_r      <= rej_s;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_cfg
        assign cfg_o[g*W +: W] = active_r[g];
    end

    assign loaded_o   = loaded_r;
    assign busy_o     = busy_s;
    assign frame_ok_o = frame_ok_r;
    assign err_o      = err_r;

endmodule

// File: tb/tb_dac_cfg_loader.sv
// Directed bench for dac_cfg_loader: table of frames plus hand-built corner
// sequences (stalled frame, update during commit, mid-frame reset, NCH=3).
module tb_dac_cfg_loader;

    logic clk = 1'b0;
    logic rst, sdi, sen, update, auto_upd, sel3;

    logic [31:0] cfg;
    logic [3:0]  loaded;
    logic        busy, fok, ferr;
    logic [23:0] cfg3;
    logic [2:0]  loaded3;
    logic        busy3, fok3, ferr3;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dac_cfg_loader #(.NCH(4), .W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .sdi        (sdi),
        .sen        (sen & ~sel3),
        .update     (update),
        .auto_upd   (auto_upd),
        .cfg_o      (cfg),
        .loaded_o   (loaded),
        .busy_o     (busy),
        .frame_ok_o (fok),
        .err_o      (ferr)
    );

    dac_cfg_loader #(.NCH(3), .W(8)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .sdi        (sdi),
        .sen        (sen & sel3),
        .update     (update),
        .auto_upd   (auto_upd),
        .cfg_o      (cfg3),
        .loaded_o   (loaded3),
        .busy_o     (busy3),
        .frame_ok_o (fok3),
        .err_o      (ferr3)
    );

    typedef struct {
        logic [3:0]  a;
        logic [7:0]  d;
        logic        flip;
        logic        au;
        logic        exp_ok;
        logic [3:0]  exp_ld;
        logic [31:0] exp_cfg;
        logic        upd;
        logic [31:0] exp_cfg_upd;
    } vec_t;

    vec_t vt[5];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Sends start, address (aw bits), data, parity (optionally flipped), MSB first.
    task automatic send_frame(input logic [3:0] a, input logic [7:0] d,
                              input logic flip, input logic tog, input int aw);
        logic bits[$];
        logic p;
        p = flip;
        bits.push_back(1'b1);
        for (int i = aw - 1; i >= 0; i--) begin
            bits.push_back(a[i]);
            p ^= a[i];
        end
        for (int i = 7; i >= 0; i--) begin
            bits.push_back(d[i]);
            p ^= d[i];
        end
        bits.push_back(p);
        foreach (bits[j]) begin
            sdi = bits[j];
            sen = 1'b1;
            tick;
            if (tog) begin
                chk("busy_bit", {31'd0, busy}, 32'd1);
                if (j < bits.size() - 1) begin
                    sen = 1'b0;
                    sdi = ~bits[j];
                    tick;
                    chk("busy_stall", {31'd0, busy}, 32'd1);
                end
            end
        end
        sen = 1'b0;
        sdi = 1'b0;
    endtask

    initial begin
        vt[0] = '{4'd2, 8'hA5, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vt[1] = '{4'd2, 8'hA5, 1'b0, 1'b0, 1'b1, 4'b0100, 32'h0000_0000, 1'b1, 32'h00A5_0000};
        vt[2] = '{4'd1, 8'h5A, 1'b0, 1'b1, 1'b1, 4'b0110, 32'h00A5_5A00, 1'b0, 32'h00A5_5A00};
        vt[3] = '{4'd3, 8'h12, 1'b0, 1'b0, 1'b1, 4'b1110, 32'h00A5_5A00, 1'b0, 32'h00A5_5A00};
        vt[4] = '{4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 4'b1110, 32'h00A5_5A00, 1'b0, 32'h00A5_5A00};

        rst = 1'b1; sdi = 1'b0; sen = 1'b0; update = 1'b0; auto_upd = 1'b0; sel3 = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        sen = 1'b1;
        tick;
        tick;
        sen = 1'b0;
        chk("rst_cfg", cfg, 32'h0);
        chk("rst_loaded", {28'd0, loaded}, 32'h0);
        chk("rst_busy_idle0", {31'd0, busy}, 32'd0);
        chk("rst_ok", {31'd0, fok}, 32'd0);
        chk("rst_err", {31'd0, ferr}, 32'd0);
        chk("rst_cfg3", {8'd0, cfg3}, 32'h0);
        chk("rst_loaded3", {29'd0, loaded3}, 32'h0);

        for (int i = 0; i < 5; i++) begin
            auto_upd = vt[i].au;
            send_frame(vt[i].a, vt[i].d, vt[i].flip, 1'b0, 2);
            chk("commit_busy", {31'd0, busy}, 32'd1);
            chk("commit_ok_early", {31'd0, fok | ferr}, 32'd0);
            tick;
            chk("frame_ok", {31'd0, fok}, {31'd0, vt[i].exp_ok});
            chk("frame_err", {31'd0, ferr}, {31'd0, ~vt[i].exp_ok});
            chk("loaded", {28'd0, loaded}, {28'd0, vt[i].exp_ld});
            chk("cfg", cfg, vt[i].exp_cfg);
            chk("busy_after", {31'd0, busy}, 32'd0);
            tick;
            chk("pulse_width", {31'd0, fok | ferr}, 32'd0);
            auto_upd = 1'b0;
            if (vt[i].upd) begin
                update = 1'b1;
                tick;
                update = 1'b0;
                chk("cfg_upd", cfg, vt[i].exp_cfg_upd);
            end
        end

        // Stalled frame with sen toggling, auto update to channel 0.
        auto_upd = 1'b1;
        send_frame(4'd0, 8'h3C, 1'b0, 1'b1, 2);
        tick;
        chk("tog_cfg", cfg, 32'h00A5_5A3C);
        chk("tog_ok", {31'd0, fok}, 32'd1);
        chk("tog_loaded", {28'd0, loaded}, 32'hF);
        auto_upd = 1'b0;
        tick;

        // Update during COMMIT; a start bit offered in COMMIT must be lost.
        send_frame(4'd1, 8'hFF, 1'b0, 1'b0, 2);
        update = 1'b1;
        sen = 1'b1;
        sdi = 1'b1;
        tick;
        update = 1'b0;
        sdi = 1'b0;
        chk("upd_commit_cfg", cfg, 32'h12A5_FF3C);
        chk("upd_commit_ok", {31'd0, fok}, 32'd1);
        chk("commit_start_lost", {31'd0, busy}, 32'd0);
        tick;
        chk("commit_start_lost2", {31'd0, busy}, 32'd0);
        sen = 1'b0;
        tick;

        // Reset after six bits of a frame, then a clean frame to channel 3.
        sen = 1'b1;
        sdi = 1'b1; tick;
        sdi = 1'b0; tick;
        sdi = 1'b1; tick;
        sdi = 1'b1; tick;
        sdi = 1'b1; tick;
        sdi = 1'b1; tick;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        sen = 1'b0;
        sdi = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mrst_cfg", cfg, 32'h0);
        chk("mrst_loaded", {28'd0, loaded}, 32'h0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        send_frame(4'd3, 8'h01, 1'b0, 1'b0, 2);
        chk("mrst_no_spurious", {31'd0, fok | ferr}, 32'd0);
        tick;
        chk("mrst_ok", {31'd0, fok}, 32'd1);
        chk("mrst_loaded2", {28'd0, loaded}, 32'h8);
        chk("mrst_cfg2", cfg, 32'h0);
        tick;
        update = 1'b1;
        tick;
        update = 1'b0;
        chk("mrst_upd", cfg, 32'h0100_0000);

        // NCH=3 build: channel 2 accepted, address 3 rejected.
        sel3 = 1'b1;
        auto_upd = 1'b1;
        send_frame(4'd2, 8'h77, 1'b0, 1'b0, 2);
        tick;
        chk("n3_ok", {31'd0, fok3}, 32'd1);
        chk("n3_loaded", {29'd0, loaded3}, 32'h4);
        chk("n3_cfg", {8'd0, cfg3}, 32'h0077_0000);
        tick;
        send_frame(4'd3, 8'h55, 1'b0, 1'b0, 2);
        tick;
        chk("n3_addr_err", {31'd0, ferr3}, 32'd1);
        chk("n3_addr_ok", {31'd0, fok3}, 32'd0);
        chk("n3_addr_loaded", {29'd0, loaded3}, 32'h4);
        chk("n3_addr_cfg", {8'd0, cfg3}, 32'h0077_0000);
        auto_upd = 1'b0;
        tick;
        update = 1'b1;
        tick;
        update = 1'b0;
        chk("n3_upd_cfg", {8'd0, cfg3}, 32'h0077_0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dac_cfg_loader.md
# dac_cfg_loader

Parametrised serial configuration loader for the DAC control path. Receives framed words on a single serial line, checks them, and writes one of `NCH` double-buffered `W`-bit channel registers. Shadow registers are copied to the active outputs on an update strobe or automatically. It replaces fixed-width, fixed-count per-field shift chains with one addressed, parity-checked, stall-tolerant receiver.

## Interface
Parameters:
- `NCH`, 4, number of configuration channels (1..16)
- `W`, 8, data bits per channel (1..16)
- `AW`, max(1, clog2(NCH)), address field width (derived, not overridable)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset; one clock, synchronous, active-high
- `sdi`  in  1  serial data, MSB-first
- `sen`  in  1  bit-valid qualifier; `sdi` is consumed only on edges where `sen`=1
- `update`  in  1  copy all shadow registers to active registers
- `auto_upd`  in  1  when 1, each committed word also goes straight to its active register
- `cfg_o`  out  NCH*W  active registers; channel k occupies bits [k*W +: W]
- `loaded_o`  out  NCH  per-channel flag: shadow written since reset
- `busy_o`  out  1  receiver not in IDLE
- `frame_ok_o`  out  1  one-cycle pulse: good frame committed
- `err_o`  out  1  one-cycle pulse: frame rejected (parity or address)

## Operation
- Frame: start bit 1, then `AW` address bits, then `W` data bits, then 1 even-parity bit. Even parity means the ones count over address+data+parity is even. Frame length is `AW+W+2` qualified bits.
- Idle line level is 0. In IDLE, zeros on qualified edges are ignored.
- FSM states: IDLE, ADDR, DATA, PAR, COMMIT.
  - IDLE -> ADDR on a qualified `sdi`=1.
  - ADDR -> DATA after `AW` qualified bits.
  - DATA -> PAR after `W` qualified bits.
  - PAR -> COMMIT on the qualified parity bit.
  - COMMIT -> IDLE unconditionally, after one cycle.
- `sen`=0 stalls ADDR/DATA/PAR indefinitely, with no timeout. COMMIT ignores `sen` and `sdi`, so a start bit presented during COMMIT is lost.
- Accept condition at COMMIT: parity correct and address < `NCH`.
  - Accepted: write shadow[addr], set `loaded_o[addr]`, pulse `frame_ok_o`.
  - Rejected: no register changes, pulse `err_o`.
- Update rules:
  - `update`=1 copies every shadow register to its active register.
  - `auto_upd`=1 with an accepted commit copies the committed channel only.
  - `update` in the same cycle as an accepted commit: the active register for that channel receives the newly committed value, and the other channels receive their shadow values.
  - `update` is legal in any state and does not disturb the receiver.
- Reset values: `cfg_o` all 0, shadows all 0, `loaded_o` 0, `busy_o` 0, `frame_ok_o` 0, `err_o` 0, state IDLE, counters 0.
- Reset mid-frame discards the partial frame. The first qualified 1 after reset is treated as a start bit.

## Timing
- Let edge E be the one that samples the parity bit. The state is COMMIT during the cycle after E.
- At edge E+1:
  - shadow, `loaded_o`, and (with `auto_upd`) `cfg_o` update.
  - `frame_ok_o`/`err_o` go high for exactly the cycle after E+1.
- `update` to `cfg_o` latency: 1 edge.
- `busy_o` is registered-state decode and is high from the edge after the start bit through the COMMIT cycle.
- Minimum frame-to-frame spacing is `AW+W+3` cycles, because of the COMMIT cycle.
- Outputs are all registered. There is no combinational path from inputs to outputs.

## Structure
- `dac_cfg_pkg` contains:
  - state enum (IDLE, ADDR, DATA, PAR, COMMIT)
  - frame-length function `AW+W+2`
  - max limits for `NCH` and `W`
- Sub-module `cfg_frame_rx` contains the FSM, bit counter, address/data shift register and parity accumulator. It outputs `addr`, `data`, a commit strobe, and ok/error. The top level holds the shadow/active banks and the update logic.

## Test plan
Defaults `NCH`=4, `W`=8. The frame for channel 2 with data 0xA5 is the bits 1,1,0,1,0,1,0,0,1,0,1,1 (12 bits, parity=1).
- Channel 2, data 0xA5, `sen` held 1, `auto_upd`=0 -> shadow2=0xA5, `loaded_o`=0100, `frame_ok_o` pulses once, `cfg_o`=0. Then `update` -> `cfg_o`[23:16]=0xA5 one edge later.
- Same frame with parity bit flipped to 0 -> `err_o` pulses, shadow2 stays 0, `loaded_o`=0000.
- Frame with `sen` toggling 1/0 every cycle and `auto_upd`=1, channel 0, data 0x3C -> `cfg_o`[7:0]=0x3C at E+1, `busy_o` high for the whole frame.
- `update` asserted in the COMMIT cycle of channel 1, data 0xFF, while shadow3=0x12 is pending -> active1=0xFF and active3=0x12 on the same edge.
- `rst` asserted after 6 bits of a frame, then a full frame for channel 3, data 0x01 -> no spurious commit, and the clean frame is accepted.
- `NCH`=3 build, address 3 with correct parity -> `err_o` pulses, no registers change.
